mem_access_unit: RTL and testbench

- Memory-access stage directly downstream of the 2-cycle execute ALU.
- Consumes the ALU's registered load/store request (tMemOp) and drives a request/grant/rvalid data-memory port.
- Aligns and extends load data, then produces a register write-back (tRegOp) for the register file.
- Stalls the pipeline while a memory transaction is outstanding.

---
 rtl/mem_access_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-access stage: request/grant/rvalid port, load align/extend, write-back.
// Optional MEM_TIMEOUT_EN aborts REQ/WAIT after TIMEOUT_CYCLES cycles.
package mem_access_pkg;
  localparam int cXLEN       = 32;
  localparam int cRegSelBitW = 5;

  typedef struct packed {
    logic                   read;
    logic                   write;
    logic [cXLEN-1:0]       addr;
    logic [cXLEN-1:0]       data;
    logic [2:0]             opType;
    logic [cRegSelBitW-1:0] rdAddr;
  } tMemOp;

  typedef struct packed {
    logic                   dv;
    logic [cRegSelBitW-1:0] addr;
    logic [cXLEN-1:0]       data;
  } tRegOp;
endpackage

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int XLEN           = cXLEN,
  parameter int REG_ADDR_W     = cRegSelBitW,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            iClk,
  input  logic            iRst,
  input  tMemOp           iMemOp,
  output logic            oStall,
  output logic            oDmemReq,
  output logic            oDmemWe,
  output logic [XLEN-1:0] oDmemAddr,
  output logic [3:0]      oDmemBe,
  output logic [XLEN-1:0] oDmemWData,
  input  logic            iDmemGnt,
  input  logic            iDmemRValid,
  input  logic [XLEN-1:0] iDmemRData,
  output tRegOp           oRegWB,
  output logic            oExcept
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_write;
  logic [XLEN-1:0]       r_addr;
  logic [XLEN-1:0]       r_data;
  logic [2:0]            r_f3;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_wbdata;
  logic                  r_except;

  logic       w_valid;
  logic       w_accept;
  logic       w_f3_ok;
  logic       w_misal;
  logic       w_illegal;
  logic       w_timeout;
  logic       w_to_hit;
  logic       w_req;
  logic [3:0] w_be;
  logic [2:0] w_f3;

  assign w_valid = iMemOp.read | iMemOp.write;
  assign w_f3    = iMemOp.opType;

  always_comb begin
    w_f3_ok = 1'b0;
    w_misal = 1'b0;
    unique case (1'b1)
      iMemOp.read:
        w_f3_ok = (w_f3 == 3'b000) || (w_f3 == 3'b001) ||
                  (w_f3 == 3'b010) || (w_f3 == 3'b100) ||
                  (w_f3 == 3'b101);
      default:
        w_f3_ok = (w_f3 == 3'b000) || (w_f3 == 3'b001) ||
                  (w_f3 == 3'b010);
    endcase
    if (w_f3[1:0] == 2'b01)
      w_misal = iMemOp.addr[0];
    else if (w_f3[1:0] == 2'b10)
      w_misal = |iMemOp.addr[1:0];
  end

  assign w_illegal = ~w_f3_ok | w_misal;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_cnt;

  assign w_to_hit = ((r_state == REQ) || (r_state == WAIT)) &&
                    (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)
      r_cnt <= '0;
    else if ((w_next != r_state) &&
             ((w_next == REQ) || (w_next == WAIT)))
      r_cnt <= '0;
    else if ((r_state == REQ) || (r_state == WAIT))
      r_cnt <= r_cnt + 1'b1;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_to_hit = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_accept = 1'b1;
          if (!w_illegal)
            w_next = REQ;
        end
      end
      REQ: begin
        if (iDmemGnt)
          w_next = r_write ? IDLE : WAIT;
        else if (w_to_hit) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      WAIT: begin
        if (iDmemRValid)
          w_next = RESP;
        else if (w_to_hit) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  function automatic logic [XLEN-1:0] load_ext(
    input logic [XLEN-1:0] rdata,
    input logic [1:0]      off,
    input logic [2:0]      f3
  );
    logic [XLEN-1:0] l;
    l = rdata >> {off, 3'b000};
    unique case (f3)
      3'b000:  load_ext = {{(XLEN-8){l[7]}}, l[7:0]};
      3'b001:  load_ext = {{(XLEN-16){l[15]}}, l[15:0]};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, l[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, l[15:0]};
      default: load_ext = l;
    endcase
  endfunction

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state  <= IDLE;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_f3     <= '0;
      r_rd     <= '0;
      r_wbdata <= '0;
      r_except <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_except <= (w_accept & w_illegal) | w_timeout;
      if (w_accept) begin
        r_write <= ~iMemOp.read;
        r_addr  <= iMemOp.addr;
        r_data  <= iMemOp.data;
        r_f3    <= iMemOp.opType;
        r_rd    <= iMemOp.rdAddr;
      end
      if ((r_state == WAIT) && iDmemRValid)
        r_wbdata <= load_ext(iDmemRData, r_addr[1:0], r_f3);
    end
  end

  always_comb begin
    unique case (r_f3[1:0])
      2'b00:   w_be = 4'b0001 << r_addr[1:0];
      2'b01:   w_be = 4'b0011 << r_addr[1:0];
      default: w_be = 4'b1111;
    endcase
  end

  assign w_req      = (r_state == REQ);
  assign oDmemReq   = w_req;
  assign oDmemWe    = w_req & r_write;
  assign oDmemAddr  = w_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign oDmemBe    = w_req ? w_be : 4'b0000;

  always_comb begin
    oDmemWData = '0;
    if (w_req && r_write) begin
      unique case (r_f3[1:0])
        2'b00:   oDmemWData = {(XLEN/8){r_data[7:0]}};
        2'b01:   oDmemWData = {(XLEN/16){r_data[15:0]}};
        default: oDmemWData = r_data;
      endcase
    end
  end

  // Accept-cycle stall is combinational; gated so reset forces it low.
  assign oStall = iRst & ((r_state != IDLE) | w_valid);

  assign oRegWB.dv   = (r_state == RESP) & (r_rd != '0);
  assign oRegWB.addr = (r_state == RESP) ? r_rd : '0;
  assign oRegWB.data = (r_state == RESP) ? r_wbdata : '0;
  assign oExcept     = r_except;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
// Timeout section runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        iClk;
  logic        iRst;
  tMemOp       iMemOp;
  logic        oStall;
  logic        oDmemReq;
  logic        oDmemWe;
  logic [31:0] oDmemAddr;
  logic [3:0]  oDmemBe;
  logic [31:0] oDmemWData;
  logic        iDmemGnt;
  logic        iDmemRValid;
  logic [31:0] iDmemRData;
  tRegOp       oRegWB;
  logic        oExcept;

  int n_chk;
  int n_pass;

  mem_access_unit #(
    .XLEN(32),
    .REG_ADDR_W(5),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .iClk(iClk),
    .iRst(iRst),
    .iMemOp(iMemOp),
    .oStall(oStall),
    .oDmemReq(oDmemReq),
    .oDmemWe(oDmemWe),
    .oDmemAddr(oDmemAddr),
    .oDmemBe(oDmemBe),
    .oDmemWData(oDmemWData),
    .iDmemGnt(iDmemGnt),
    .iDmemRValid(iDmemRValid),
    .iDmemRData(iDmemRData),
    .oRegWB(oRegWB),
    .oExcept(oExcept)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge iClk);
    #2;
  endtask

  task automatic set_op(input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] f3, input logic [4:0] rda);
    iMemOp        = '0;
    iMemOp.read   = rd;
    iMemOp.write  = wr;
    iMemOp.addr   = a;
    iMemOp.data   = d;
    iMemOp.opType = f3;
    iMemOp.rdAddr = rda;
  endtask

  task automatic run_load(input string tag,
                          input logic [31:0] a, input logic [2:0] f3,
                          input logic [4:0] rda, input logic [31:0] rdata,
                          input logic [31:0] exp, input logic [3:0] be,
                          input logic exp_dv);
    set_op(1'b1, 1'b0, a, 32'h0, f3, rda);
    #1 chk({tag, ".stall_acc"}, oStall, 1);
    tick();
    iMemOp = '0;
    iDmemGnt = 1'b1;
    #1;
    chk({tag, ".req"}, oDmemReq, 1);
    chk({tag, ".we"}, oDmemWe, 0);
    chk({tag, ".addr"}, oDmemAddr, {a[31:2], 2'b00});
    chk({tag, ".be"}, oDmemBe, be);
    chk({tag, ".stall_req"}, oStall, 1);
    tick();
    iDmemGnt = 1'b0;
    iDmemRValid = 1'b1;
    iDmemRData = rdata;
    #1;
    chk({tag, ".req_wait"}, oDmemReq, 0);
    chk({tag, ".stall_wait"}, oStall, 1);
    chk({tag, ".dv_wait"}, oRegWB.dv, 0);
    tick();
    iDmemRValid = 1'b0;
    iDmemRData = 32'h0;
    #1;
    chk({tag, ".dv"}, oRegWB.dv, exp_dv);
    chk({tag, ".stall_resp"}, oStall, 1);
    if (exp_dv) begin
      chk({tag, ".wb_addr"}, oRegWB.addr, rda);
      chk({tag, ".wb_data"}, oRegWB.data, exp);
    end
    tick();
    #1;
    chk({tag, ".dv_after"}, oRegWB.dv, 0);
    chk({tag, ".stall_after"}, oStall, 0);
  endtask

  task automatic run_store(input string tag,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] f3, input int gnt_dly,
                           input logic [3:0] be, input logic [31:0] wd);
    set_op(1'b0, 1'b1, a, d, f3, 5'd0);
    #1 chk({tag, ".stall_acc"}, oStall, 1);
    tick();
    iMemOp = '0;
    for (int i = 0; i <= gnt_dly; i++) begin
      iDmemGnt = (i == gnt_dly);
      #1;
      chk({tag, ".req"}, oDmemReq, 1);
      chk({tag, ".we"}, oDmemWe, 1);
      chk({tag, ".addr"}, oDmemAddr, {a[31:2], 2'b00});
      chk({tag, ".be"}, oDmemBe, be);
      chk({tag, ".wdata"}, oDmemWData, wd);
      chk({tag, ".stall"}, oStall, 1);
      tick();
    end
    iDmemGnt = 1'b0;
    #1;
    chk({tag, ".req_done"}, oDmemReq, 0);
    chk({tag, ".stall_done"}, oStall, 0);
    chk({tag, ".dv_done"}, oRegWB.dv, 0);
  endtask

  task automatic run_bad(input string tag, input logic rd,
                         input logic [31:0] a, input logic [2:0] f3);
    set_op(rd, ~rd, a, 32'h1234_5678, f3, 5'd7);
    #1 chk({tag, ".req_acc"}, oDmemReq, 0);
    tick();
    iMemOp = '0;
    #1;
    chk({tag, ".except"}, oExcept, 1);
    chk({tag, ".req"}, oDmemReq, 0);
    chk({tag, ".stall"}, oStall, 0);
    tick();
    #1;
    chk({tag, ".except_pulse"}, oExcept, 0);
    chk({tag, ".req2"}, oDmemReq, 0);
    chk({tag, ".dv"}, oRegWB.dv, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stall"}, oStall, 0);
    chk({tag, ".req"}, oDmemReq, 0);
    chk({tag, ".we"}, oDmemWe, 0);
    chk({tag, ".addr"}, oDmemAddr, 0);
    chk({tag, ".be"}, oDmemBe, 0);
    chk({tag, ".wdata"}, oDmemWData, 0);
    chk({tag, ".wb"}, {26'h0, oRegWB.dv, oRegWB.addr}, 0);
    chk({tag, ".wb_data"}, oRegWB.data, 0);
    chk({tag, ".except"}, oExcept, 0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    iRst = 1'b0;
    iMemOp = '0;
    iDmemGnt = 1'b0;
    iDmemRValid = 1'b0;
    iDmemRData = 32'h0;
    #12;
    chk_all_zero("reset");
    iRst = 1'b1;
    tick();

    run_load("lw", 32'h100, 3'b010, 5'd5, 32'hDEADBEEF,
             32'hDEADBEEF, 4'b1111, 1'b1);
    run_load("lb", 32'h103, 3'b000, 5'd6, 32'h80FF_FFFF,
             32'hFFFF_FF80, 4'b1000, 1'b1);
    run_load("lbu", 32'h103, 3'b100, 5'd7, 32'h80FF_FFFF,
             32'h0000_0080, 4'b1000, 1'b1);
    run_load("lhu", 32'h102, 3'b101, 5'd8, 32'h80FF_FFFF,
             32'h0000_80FF, 4'b1100, 1'b1);
    run_load("lh", 32'h102, 3'b001, 5'd9, 32'h80FF_FFFF,
             32'hFFFF_80FF, 4'b1100, 1'b1);
    run_load("lw_x0", 32'h104, 3'b010, 5'd0, 32'h1111_2222,
             32'h0, 4'b1111, 1'b0);

    run_store("sb", 32'h201, 32'h0000_00A5, 3'b000, 4,
              4'b0010, 32'hA5A5_A5A5);
    run_store("sh", 32'h202, 32'h0000_1234, 3'b001, 0,
              4'b1100, 32'h1234_1234);
    run_store("sw", 32'h204, 32'hCAFE_F00D, 3'b010, 1,
              4'b1111, 32'hCAFE_F00D);

    run_bad("lh_mis", 1'b1, 32'h101, 3'b001);
    run_bad("sw_mis", 1'b0, 32'h102, 3'b010);
    run_bad("ld_f3", 1'b1, 32'h100, 3'b011);
    run_bad("st_f3", 1'b0, 32'h100, 3'b100);

    set_op(1'b1, 1'b0, 32'h300, 32'h0, 3'b010, 5'd3);
    tick();
    iMemOp = '0;
    iDmemGnt = 1'b1;
    tick();
    iDmemGnt = 1'b0;
    #1 chk("rst.stall_pre", oStall, 1);
    iRst = 1'b0;
    #1 chk_all_zero("rst_wait");
    tick();
    iRst = 1'b1;
    iDmemRValid = 1'b1;
    iDmemRData = 32'h5555_AAAA;
    tick();
    iDmemRValid = 1'b0;
    #1;
    chk("rst.dv1", oRegWB.dv, 0);
    chk("rst.stall1", oStall, 0);
    tick();
    #1 chk("rst.dv2", oRegWB.dv, 0);

`ifdef MEM_TIMEOUT_EN
    set_op(1'b1, 1'b0, 32'h400, 32'h0, 3'b010, 5'd4);
    tick();
    iMemOp = '0;
    iDmemGnt = 1'b1;
    tick();
    iDmemGnt = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to.stall", oStall, 1);
      chk("to.except_early", oExcept, 0);
      tick();
    end
    #1;
    chk("to.except", oExcept, 1);
    chk("to.stall_end", oStall, 0);
    chk("to.dv", oRegWB.dv, 0);
    tick();
    #1 chk("to.except_pulse", oExcept, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
